// File: rtl/mem_write_tap_if.sv
// rtl/mem_write_tap_if.sv - CPU write-port and snoop output stream bundle for mem_write_tap
interface mem_write_tap_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16,
  parameter int WIN_W  = 1
);
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_data;
  logic              cpu_we;
  logic              out_valid;
  logic              out_ready;
  logic [WIN_W-1:0]  out_win;
  logic [ADDR_W-1:0] out_offset;
  logic [DATA_W-1:0] out_data;

  modport master (
    output cpu_addr, cpu_data, cpu_we, out_ready,
    input  out_valid, out_win, out_offset, out_data
  );

  modport slave (
    input  cpu_addr, cpu_data, cpu_we, out_ready,
    output out_valid, out_win, out_offset, out_data
  );
endinterface

// File: rtl/mem_write_tap.sv
// rtl/mem_write_tap.sv - windowed CPU data-memory write snoop with FWFT queue, last-value and drop count
module mem_write_tap #(
  parameter int                        ADDR_W     = 15,
  parameter int                        DATA_W     = 16,
  parameter int                        NUM_WIN    = 2,
  parameter logic [NUM_WIN*ADDR_W-1:0] WIN_BASE   = {15'd24577, 15'd16384},
  parameter logic [NUM_WIN*ADDR_W-1:0] WIN_SIZE   = {15'd1, 15'd8192},
  parameter int                        FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  mem_write_tap_if.slave              bus,
  output logic [NUM_WIN*DATA_W-1:0]   last_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [7:0]                  drop_count
);
  localparam int WIN_W = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [ADDR_W:0]   w_addr_x;
  logic [ADDR_W:0]   w_base_x;
  logic [ADDR_W:0]   w_size_x;
  logic              w_hit;
  logic [WIN_W-1:0]  w_hit_win;
  logic [ADDR_W-1:0] w_hit_off;

  // Scan from the top index down so the lowest matching window is the one kept.
  always_comb begin
    w_addr_x  = {1'b0, bus.cpu_addr};
    w_base_x  = '0;
    w_size_x  = '0;
    w_hit     = 1'b0;
    w_hit_win = '0;
    w_hit_off = '0;
    for (int w = NUM_WIN - 1; w >= 0; w--) begin
      w_base_x = {1'b0, WIN_BASE[w*ADDR_W +: ADDR_W]};
      w_size_x = {1'b0, WIN_SIZE[w*ADDR_W +: ADDR_W]};
      if ((w_size_x != '0) && (w_addr_x >= w_base_x) && (w_addr_x < (w_base_x + w_size_x))) begin
        w_hit     = 1'b1;
        w_hit_win = WIN_W'(w);
        w_hit_off = bus.cpu_addr - w_base_x[ADDR_W-1:0];
      end
    end
  end

  logic              r_cap_valid;
  logic [WIN_W-1:0]  r_cap_win;
  logic [ADDR_W-1:0] r_cap_off;
  logic [DATA_W-1:0] r_cap_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cap_valid <= 1'b0;
      r_cap_win   <= '0;
      r_cap_off   <= '0;
      r_cap_data  <= '0;
    end else begin
      r_cap_valid <= bus.cpu_we && w_hit;
      r_cap_win   <= w_hit_win;
      r_cap_off   <= w_hit_off;
      r_cap_data  <= bus.cpu_data;
    end
  end

  logic [PTR_W:0]    r_wr_ptr;
  logic [PTR_W:0]    r_rd_ptr;
  logic [WIN_W-1:0]  r_mem_win  [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_mem_off  [FIFO_DEPTH];
  logic [DATA_W-1:0] r_mem_data [FIFO_DEPTH];
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_pop   = !w_empty && bus.out_ready;
  // A full queue still accepts when the head leaves in the same cycle.
  assign w_push  = r_cap_valid && (!w_full || w_pop);
  assign w_drop  = r_cap_valid && !w_push;

  // Storage is cleared on reset so the head reads zero while the queue is empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_win[i]  <= '0;
        r_mem_off[i]  <= '0;
        r_mem_data[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem_win[r_wr_ptr[PTR_W-1:0]]  <= r_cap_win;
        r_mem_off[r_wr_ptr[PTR_W-1:0]]  <= r_cap_off;
        r_mem_data[r_wr_ptr[PTR_W-1:0]] <= r_cap_data;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  logic [NUM_WIN*DATA_W-1:0] r_last_data;
  logic [7:0]                r_drop_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_data  <= '0;
      r_drop_count <= '0;
    end else begin
      if (r_cap_valid) begin
        for (int w = 0; w < NUM_WIN; w++) begin
          if (r_cap_win == WIN_W'(w)) begin
            r_last_data[w*DATA_W +: DATA_W] <= r_cap_data;
          end
        end
      end
      if (w_drop && (r_drop_count != 8'hFF)) begin
        r_drop_count <= r_drop_count + 8'd1;
      end
    end
  end

  assign bus.out_valid  = !w_empty;
  assign bus.out_win    = r_mem_win[r_rd_ptr[PTR_W-1:0]];
  assign bus.out_offset = r_mem_off[r_rd_ptr[PTR_W-1:0]];
  assign bus.out_data   = r_mem_data[r_rd_ptr[PTR_W-1:0]];
  assign last_data      = r_last_data;
  assign fifo_level     = r_wr_ptr - r_rd_ptr;
  assign drop_count     = r_drop_count;
endmodule

// File: tb/tb_mem_write_tap.sv
// tb/tb_mem_write_tap.sv - scoreboard bench for mem_write_tap against a queue-level reference model
module tb_mem_write_tap;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] last_data;
  logic [2:0]  fifo_level;
  logic [7:0]  drop_count;

  mem_write_tap_if #(.ADDR_W(15), .DATA_W(16), .WIN_W(1)) bus ();

  mem_write_tap #(
    .ADDR_W(15), .DATA_W(16), .NUM_WIN(2),
    .WIN_BASE({15'd24577, 15'd16384}),
    .WIN_SIZE({15'd1, 15'd8192}),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .last_data(last_data), .fifo_level(fifo_level), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          win;
    int          off;
    logic [15:0] data;
  } ent_t;

  ent_t        sb_q[$];
  int          m_base[2] = '{16384, 24577};
  int          m_size[2] = '{8192, 1};
  int          m_level = 0;
  int          m_drop = 0;
  logic [31:0] m_last = '0;
  bit          m_cap_hit = 0;
  ent_t        m_cap;
  bit          mon_en = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the queue of accepted writes, its occupancy and the one-deep capture.
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_level   = 0;
        m_drop    = 0;
        m_last    = '0;
        m_cap_hit = 0;
        sb_q.delete();
      end else begin
        bit pop;
        int a;
        pop = (m_level > 0) && bus.out_ready;
        if (m_cap_hit) begin
          m_last[m_cap.win*16 +: 16] = m_cap.data;
          if (m_level < DEPTH || pop) begin
            sb_q.push_back(m_cap);
            m_level++;
          end else if (m_drop < 255) begin
            m_drop++;
          end
        end
        if (pop) m_level--;
        m_cap_hit = 0;
        a = int'(bus.cpu_addr);
        if (bus.cpu_we) begin
          for (int w = 0; w < 2; w++) begin
            if (!m_cap_hit && m_size[w] != 0 && a >= m_base[w] && a < m_base[w] + m_size[w]) begin
              m_cap_hit  = 1;
              m_cap.win  = w;
              m_cap.off  = a - m_base[w];
              m_cap.data = bus.cpu_data;
            end
          end
        end
      end
    end
  end

  // Monitor: compares visible state every cycle and each popped head against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("level", 64'(fifo_level), 64'(m_level));
        check("valid", 64'(bus.out_valid), 64'(m_level > 0));
        check("drop_count", 64'(drop_count), 64'(m_drop));
        check("last_data", 64'(last_data), 64'(m_last));
        if (bus.out_valid && bus.out_ready) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: win %0d off %0d data %0h with empty scoreboard",
                     bus.out_win, bus.out_offset, bus.out_data);
          end else begin
            ent_t e;
            e = sb_q.pop_front();
            check("out_win", 64'(bus.out_win), 64'(e.win));
            check("out_offset", 64'(bus.out_offset), 64'(e.off));
            check("out_data", 64'(bus.out_data), 64'(e.data));
          end
        end
      end
    end
  end

  task automatic cyc(input logic rst, input logic we, input int addr, input logic [15:0] d,
                     input logic rdy);
    @(posedge clk);
    #1;
    reset         = rst;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr[14:0];
    bus.cpu_data  = d;
    bus.out_ready = rdy;
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 16'h0, 0);
    cyc(0, 0, 0, 16'h0, 0);
  endtask

  initial begin
    logic [15:0] d6;
    int          bnd[5];
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_data  = '0;
    bus.out_ready = 1'b0;
    bnd = '{16383, 16384, 24575, 24576, 24577};

    cyc(1, 0, 0, 16'h0, 0);
    cyc(1, 0, 0, 16'h0, 0);
    cyc(0, 0, 0, 16'h0, 0);
    mon_en = 1;
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_win", 64'(bus.out_win), 64'd0);
    check("rst_offset", 64'(bus.out_offset), 64'd0);
    check("rst_data", 64'(bus.out_data), 64'd0);

    cyc(0, 1, 16384, 16'h00FF, 1);
    cyc(0, 0, 0, 16'h0, 1);
    check("single_not_yet", 64'(bus.out_valid), 64'd0);
    cyc(0, 0, 0, 16'h0, 1);
    check("single_valid", 64'(bus.out_valid), 64'd1);
    check("single_data", 64'(bus.out_data), 64'h00FF);
    check("single_last", 64'(last_data[15:0]), 64'h00FF);
    cyc(0, 0, 0, 16'h0, 1);
    check("single_drained", 64'(fifo_level), 64'd0);

    foreach (bnd[i]) cyc(0, 1, bnd[i], 16'(16'hA000 + i), 1);
    repeat (4) cyc(0, 0, 0, 16'h0, 1);

    do_reset();
    d6 = '0;
    for (int i = 0; i < 6; i++) begin
      d6 = 16'($urandom);
      cyc(0, 1, 16384 + i, d6, 0);
    end
    cyc(0, 0, 0, 16'h0, 0);
    cyc(0, 0, 0, 16'h0, 0);
    check("bp_level", 64'(fifo_level), 64'd4);
    check("bp_drop", 64'(drop_count), 64'd2);
    check("bp_last", 64'(last_data[15:0]), 64'(d6));
    repeat (6) cyc(0, 0, 0, 16'h0, 1);

    do_reset();
    for (int i = 0; i < 4; i++) cyc(0, 1, 20000 + i, 16'($urandom), 0);
    cyc(0, 0, 0, 16'h0, 0);
    cyc(0, 1, 24577, 16'h5A5A, 0);
    cyc(0, 0, 0, 16'h0, 1);
    cyc(0, 0, 0, 16'h0, 0);
    check("fullpop_level", 64'(fifo_level), 64'd4);
    check("fullpop_drop", 64'(drop_count), 64'd0);
    check("fullpop_last1", 64'(last_data[31:16]), 64'h5A5A);
    repeat (6) cyc(0, 0, 0, 16'h0, 1);

    do_reset();
    for (int i = 0; i < 304; i++) cyc(0, 1, 16384 + (i % 8192), 16'(i), 0);
    cyc(0, 0, 0, 16'h0, 0);
    cyc(0, 0, 0, 16'h0, 0);
    check("sat_drop", 64'(drop_count), 64'd255);
    check("sat_level", 64'(fifo_level), 64'd4);

    do_reset();
    for (int i = 0; i < 3; i++) cyc(0, 1, 17000 + i, 16'($urandom), 0);
    cyc(0, 1, 17003, 16'hDEAD, 0);
    cyc(1, 0, 0, 16'h0, 0);
    cyc(0, 0, 0, 16'h0, 0);
    check("midrst_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_level", 64'(fifo_level), 64'd0);
    check("midrst_last", 64'(last_data), 64'd0);
    repeat (4) cyc(0, 0, 0, 16'h0, 1);
    check("midrst_no_ghost", 64'(fifo_level), 64'd0);

    for (int i = 0; i < 400; i++) begin
      int a;
      case ($urandom_range(0, 5))
        0: a = 16384 + $urandom_range(0, 8191);
        1: a = 24577;
        2: a = 24576;
        3: a = 16383;
        4: a = 24575;
        default: a = $urandom_range(0, 32767);
      endcase
      cyc(0, ($urandom_range(0, 9) < 7), a, 16'($urandom), 1'($urandom_range(0, 1)));
    end
    repeat (10) cyc(0, 0, 0, 16'h0, 1);
    check("final_drained", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
